// File: rtl/pipe_if_ctrl.sv
// Fetch-stage controller: owns the PC and shares the instruction RAM
// between pipeline fetch and an external program loader.
module pipe_if_ctrl #(
  parameter logic [31:0] PC_RESET = 32'h0000_0000,
  parameter int          ADDR_W   = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       npc,
  input  logic              stall,
  input  logic              ld_req,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [31:0]       ld_data,
  input  logic              ld_last,
  output logic              ld_ack,
  output logic [31:0]       pc,
  output logic              ram_ena,
  output logic              ram_wena,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  output logic              fetch_valid,
  output logic              loading,
  output logic [ADDR_W:0]   ld_count
);

  typedef enum logic [1:0] {
    RUN,
    DRAIN,
    LOAD,
    RESUME
  } state_e;

  localparam logic [ADDR_W:0] CNT_MAX = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] CNT_ONE = {{ADDR_W{1'b0}}, 1'b1};

  state_e            state_q, state_d;
  logic [31:0]       pc_q, pc_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RUN;
      pc_q    <= PC_RESET;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    cnt_d       = cnt_q;
    ld_ack      = 1'b0;
    ram_ena     = 1'b0;
    ram_wena    = 1'b0;
    ram_addr    = '0;
    ram_wdata   = '0;
    fetch_valid = 1'b0;
    case (state_q)
      RUN: begin
        ram_ena     = 1'b1;
        ram_addr    = pc_q[ADDR_W+1:2];
        fetch_valid = 1'b1;
        // a loader request outranks both stall and npc
        if (ld_req) begin
          state_d = DRAIN;
        end else if (!stall) begin
          pc_d = npc;
        end
      end
      DRAIN: begin
        cnt_d   = '0;
        state_d = LOAD;
      end
      LOAD: begin
        ram_ena   = ld_req;
        ram_wena  = ld_req;
        ld_ack    = ld_req;
        ram_addr  = ld_addr;
        ram_wdata = ld_data;
        if (ld_req) begin
          if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + CNT_ONE;
          end
          if (ld_last) begin
            state_d = RESUME;
          end
        end
      end
      RESUME: begin
        pc_d    = PC_RESET;
        state_d = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  assign pc       = pc_q;
  assign ld_count = cnt_q;
  assign loading  = (state_q != RUN);

endmodule

// File: tb/tb_pipe_if_ctrl.sv
// Bench for pipe_if_ctrl: phase-level model checked every negedge
// plus directed literal expectations.
module tb_pipe_if_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] npc;
  logic        stall;
  logic        ld_req;
  logic [4:0]  ld_addr;
  logic [31:0] ld_data;
  logic        ld_last;
  logic        ld_ack;
  logic [31:0] pc;
  logic        ram_ena;
  logic        ram_wena;
  logic [4:0]  ram_addr;
  logic [31:0] ram_wdata;
  logic        fetch_valid;
  logic        loading;
  logic [5:0]  ld_count;

  int checks = 0;
  int fails  = 0;

  logic [31:0] mem [32];

  always #5 clk = ~clk;

  pipe_if_ctrl #(.PC_RESET(32'h0), .ADDR_W(5)) dut (
    .clk(clk), .rst(rst), .npc(npc), .stall(stall),
    .ld_req(ld_req), .ld_addr(ld_addr), .ld_data(ld_data),
    .ld_last(ld_last), .ld_ack(ld_ack), .pc(pc),
    .ram_ena(ram_ena), .ram_wena(ram_wena), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .fetch_valid(fetch_valid),
    .loading(loading), .ld_count(ld_count)
  );

  always @(posedge clk)
    if (ram_ena && ram_wena) mem[ram_addr] <= ram_wdata;

  task automatic chk(input string n, input logic [31:0] a,
                     input logic [31:0] e);
    checks++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s t=%0t got=%h exp=%h", n, $time, a, e);
    end
  endtask

  // phases: 0 running, 1 draining, 2 loading, 3 resuming
  int          m_ph;
  logic [31:0] m_pc;
  int          m_cnt;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_ph = 0; m_pc = 32'h0; m_cnt = 0;
    end else if (m_ph == 0) begin
      if (ld_req) m_ph = 1;
      else if (!stall) m_pc = npc;
    end else if (m_ph == 1) begin
      m_cnt = 0; m_ph = 2;
    end else if (m_ph == 2) begin
      if (ld_req) begin
        m_cnt = (m_cnt + 1 > 32) ? 32 : m_cnt + 1;
        if (ld_last) m_ph = 3;
      end
    end else begin
      m_pc = 32'h0; m_ph = 0;
    end
  end

  always @(negedge clk) begin
    chk("m_pc", pc, m_pc);
    chk("m_count", ld_count, m_cnt);
    chk("m_loading", loading, m_ph != 0);
    chk("m_fvalid", fetch_valid, m_ph == 0);
    if (m_ph == 0) begin
      chk("m_run_ena", ram_ena, 1);
      chk("m_run_wena", ram_wena, 0);
      chk("m_run_addr", ram_addr, m_pc[6:2]);
      chk("m_run_wdata", ram_wdata, 0);
      chk("m_run_ack", ld_ack, 0);
    end else if (m_ph == 2) begin
      chk("m_ld_ena", ram_ena, ld_req);
      chk("m_ld_wena", ram_wena, ld_req);
      chk("m_ld_ack", ld_ack, ld_req);
      if (ld_req) begin
        chk("m_ld_addr", ram_addr, ld_addr);
        chk("m_ld_wdata", ram_wdata, ld_data);
      end
    end else begin
      chk("m_idle_ena", ram_ena, 0);
      chk("m_idle_ack", ld_ack, 0);
    end
  end

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0; npc = '0; stall = 1'b0; ld_req = 1'b0;
    ld_addr = '0; ld_data = '0; ld_last = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("rst_pc", pc, 32'h0);
    chk("rst_ena", ram_ena, 1);
    chk("rst_addr", ram_addr, 0);
    chk("rst_fv", fetch_valid, 1);
    chk("rst_loading", loading, 0);
    chk("rst_cnt", ld_count, 0);
    repeat (2) cyc;
    rst = 1'b0; npc = 32'h4;
    cyc; chk("pc_4", pc, 32'h4); npc = 32'h8;
    cyc; chk("pc_8", pc, 32'h8); stall = 1'b1; npc = 32'hC;
    for (int i = 0; i < 3; i++) begin
      cyc; chk("stall_hold", pc, 32'h8);
    end
    stall = 1'b0;
    cyc; chk("pc_c", pc, 32'hC); npc = 32'h10;
    cyc; chk("pc_10", pc, 32'h10);

    ld_req = 1'b1; ld_addr = 5'd0; ld_data = 32'hA0;
    cyc;
    chk("drain_loading", loading, 1);
    chk("drain_fv", fetch_valid, 0);
    chk("drain_ena", ram_ena, 0);
    chk("drain_pc", pc, 32'h10);
    cyc;
    for (int i = 0; i < 4; i++) begin
      ld_addr = 5'(i); ld_data = 32'hA0 + i; ld_last = (i == 3);
      #1;
      chk("b_ack", ld_ack, 1);
      chk("b_wena", ram_wena, 1);
      chk("b_addr", ram_addr, i);
      chk("b_wdata", ram_wdata, 32'hA0 + i);
      cyc;
    end
    ld_req = 1'b0; ld_last = 1'b0; npc = 32'h20;
    #1;
    chk("resume_cnt", ld_count, 4);
    chk("resume_loading", loading, 1);
    chk("resume_ack", ld_ack, 0);
    cyc;
    chk("restart_pc", pc, 32'h0);
    chk("restart_addr", ram_addr, 0);
    chk("restart_loading", loading, 0);
    cyc; chk("run_pc_20", pc, 32'h20);

    ld_req = 1'b1; ld_addr = 5'd5; ld_data = 32'hB5;
    cyc; cyc;
    #1 chk("gap_ack0", ld_ack, 1);
    cyc;
    ld_req = 1'b0; ld_addr = 5'd9; ld_data = 32'hDEAD;
    #1;
    chk("gap_ena", ram_ena, 0);
    chk("gap_ack", ld_ack, 0);
    chk("gap_cnt", ld_count, 1);
    cyc;
    chk("gap2_ena", ram_ena, 0);
    chk("gap2_cnt", ld_count, 1);
    cyc;
    ld_req = 1'b1; ld_addr = 5'd6; ld_data = 32'hB6; ld_last = 1'b1;
    #1;
    chk("gap_ack1", ld_ack, 1);
    chk("gap_addr1", ram_addr, 6);
    cyc;
    ld_req = 1'b0; ld_last = 1'b0;
    #1 chk("gap_cnt2", ld_count, 2);
    cyc; chk("gap_run_pc", pc, 32'h0);
    cyc; chk("gap_run_pc20", pc, 32'h20);

    stall = 1'b1; ld_req = 1'b1; npc = 32'h40;
    ld_addr = 5'd0; ld_data = 32'hC00;
    cyc;
    chk("prio_loading", loading, 1);
    chk("prio_pc", pc, 32'h20);
    stall = 1'b0;
    cyc;
    for (int i = 0; i < 33; i++) begin
      ld_addr = 5'(i % 32); ld_data = 32'hC00 + i;
      ld_last = (i == 32);
      #1 chk("sat_ack", ld_ack, 1);
      cyc;
    end
    ld_req = 1'b0; ld_last = 1'b0;
    #1 chk("sat_cnt", ld_count, 32);
    cyc;
    chk("sat_run", loading, 0);
    chk("mem_c02", mem[2], 32'hC02);

    ld_req = 1'b1; ld_addr = 5'd0; ld_data = 32'hD0;
    cyc; cyc; cyc;
    ld_addr = 5'd1; ld_data = 32'hD1;
    cyc;
    ld_addr = 5'd2; ld_data = 32'hD2;
    #1 rst = 1'b1;
    #1;
    chk("mid_loading", loading, 0);
    chk("mid_pc", pc, 32'h0);
    chk("mid_wena", ram_wena, 0);
    chk("mid_ena", ram_ena, 1);
    chk("mid_fv", fetch_valid, 1);
    chk("mid_ack", ld_ack, 0);
    cyc;
    rst = 1'b0; ld_req = 1'b0; npc = 32'h4;
    #1;
    chk("mid_mem0", mem[0], 32'hD0);
    chk("mid_mem1", mem[1], 32'hD1);
    chk("mid_mem2", mem[2], 32'hC02);
    chk("mid_cnt", ld_count, 0);
    cyc; chk("post_pc", pc, 32'h4);
    repeat (2) cyc;

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
